// File: rtl/alu.sv
// Registered 32-bit RV32I integer ALU for the execute stage.
// Op code is {funct7[5], funct3}; result and zero flag appear one cycle after the inputs.
module alu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_input_a,
  input  logic [31:0] i_input_b,
  input  logic [3:0]  i_alu_op,
  output logic [31:0] o_result,
  output logic        o_zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic [31:0] result_reg;
  logic [31:0] result_next;
  logic        zero_reg;
  logic        zero_next;
  logic [4:0]  shamt;

  // Only the low five bits of operand B select the shift distance.
  assign shamt = i_input_b[4:0];

  always_comb begin
    result_next = 32'h0;
    case (i_alu_op)
      OP_ADD:  result_next = i_input_a + i_input_b;
      OP_SLL:  result_next = i_input_a << shamt;
      OP_SLT:  result_next = {31'h0, $signed(i_input_a) < $signed(i_input_b)};
      OP_SLTU: result_next = {31'h0, i_input_a < i_input_b};
      OP_XOR:  result_next = i_input_a ^ i_input_b;
      OP_SRL:  result_next = i_input_a >> shamt;
      OP_OR:   result_next = i_input_a | i_input_b;
      OP_AND:  result_next = i_input_a & i_input_b;
      OP_SUB:  result_next = i_input_a - i_input_b;
      OP_SRA:  result_next = $unsigned($signed(i_input_a) >>> shamt);
      default: result_next = 32'h0;
    endcase
  end

  // Zero flag derives from the same value being registered so the pair never disagrees.
  assign zero_next = (result_next == 32'h0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      result_reg <= 32'h0;
      zero_reg   <= 1'b1;
    end else begin
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

  assign o_result = result_reg;
  assign o_zero   = zero_reg;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered RV32I ALU.
// Each vector is applied for one cycle and its result checked just after the next edge.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] result;
  logic        zero;

  int checks;
  int errors;

  alu dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_input_a (a),
    .i_input_b (b),
    .i_alu_op  (op),
    .o_result  (result),
    .o_zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one operation for a single cycle and check result and zero flag after the edge.
  task automatic run_vec(input string tag, input logic [3:0] v_op, input logic [31:0] v_a,
                         input logic [31:0] v_b, input logic [31:0] exp_result);
    logic exp_zero;
    exp_zero = (exp_result == 32'h0);
    op = v_op;
    a  = v_a;
    b  = v_b;
    @(posedge clk);
    #1;
    $display("vec %-10s op=%b a=%h b=%h -> result=%h zero=%b", tag, v_op, v_a, v_b, result, zero);
    check({tag, "_res"}, result, exp_result);
    check({tag, "_zero"}, {31'h0, zero}, {31'h0, exp_zero});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a   = 32'hdeadbeef;
    b   = 32'h1;
    op  = 4'b0000;

    // Reset held for two edges with live ADD inputs.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      $display("reset cycle %0d result=%h zero=%b", i, result, zero);
      check("rst_res", result, 32'h0);
      check("rst_zero", {31'h0, zero}, 32'h1);
    end
    rst = 1'b0;
    run_vec("post_rst", 4'b0000, 32'hdeadbeef, 32'h1, 32'hdeadbef0);

    // Arithmetic
    run_vec("add", 4'b0000, 32'h0000adde, 32'hefbe0000, 32'hefbeadde);
    run_vec("sub", 4'b1000, 32'haaaa007f, 32'h5555001c, 32'h55550063);
    run_vec("sub_eq", 4'b1000, 32'h12345678, 32'h12345678, 32'h0);
    run_vec("add_wrap", 4'b0000, 32'hffffffff, 32'h1, 32'h0);

    // Shifts by 12 with upper bits of b set
    run_vec("sll", 4'b0001, 32'h0000ffff, 32'hffffff0c, 32'h0ffff000);
    run_vec("srl", 4'b0101, 32'hffff0000, 32'hffffff0c, 32'h000ffff0);
    run_vec("sra_neg", 4'b1101, 32'hffff0000, 32'hffffff0c, 32'hfffffff0);
    run_vec("sra_pos", 4'b1101, 32'h7fff0000, 32'hffffff0c, 32'h0007fff0);

    // Compares
    run_vec("slt", 4'b0010, 32'hfffc0000, 32'h7fffffff, 32'h1);
    run_vec("sltu", 4'b0011, 32'hfffc0000, 32'h7fffffff, 32'h0);
    run_vec("slt_eq", 4'b0010, 32'hffffffff, 32'hffffffff, 32'h0);

    // Logic
    run_vec("or", 4'b0110, 32'h5555001c, 32'haaaa007f, 32'hffff007f);
    run_vec("and", 4'b0111, 32'h5555001c, 32'haaaa007f, 32'h0000001c);
    run_vec("xor", 4'b0100, 32'h5555aaaa, 32'haaaaffff, 32'hffff5555);

    // Back-to-back sweep over all ten ops plus shift-by-zero and illegal codes
    run_vec("b2b_add", 4'b0000, 32'h1, 32'h2, 32'h3);
    run_vec("b2b_sll", 4'b0001, 32'h1, 32'h1f, 32'h80000000);
    run_vec("b2b_slt", 4'b0010, 32'h5, 32'h5, 32'h0);
    run_vec("b2b_sltu", 4'b0011, 32'h3, 32'h4, 32'h1);
    run_vec("b2b_xor", 4'b0100, 32'hff00ff00, 32'h0f0f0f0f, 32'hf00ff00f);
    run_vec("b2b_srl", 4'b0101, 32'h80000000, 32'h1f, 32'h1);
    run_vec("b2b_or", 4'b0110, 32'h0, 32'h0, 32'h0);
    run_vec("b2b_and", 4'b0111, 32'hf0f0f0f0, 32'hffffffff, 32'hf0f0f0f0);
    run_vec("b2b_sub", 4'b1000, 32'h0, 32'h1, 32'hffffffff);
    run_vec("b2b_sra0", 4'b1101, 32'h80000000, 32'h20, 32'h80000000);
    run_vec("sll0", 4'b0001, 32'h12345678, 32'hffffffe0, 32'h12345678);
    run_vec("ill_1111", 4'b1111, 32'h12345678, 32'h9abcdef0, 32'h0);
    run_vec("ill_1001", 4'b1001, 32'hffffffff, 32'h1, 32'h0);
    run_vec("ill_1100", 4'b1100, 32'h80000000, 32'h3, 32'h0);
    run_vec("ill_1110", 4'b1110, 32'h7, 32'h7, 32'h0);
    run_vec("after_ill", 4'b0110, 32'h00f0, 32'h0f00, 32'h0ff0);

    // Reset mid-stream discards the in-flight result
    op  = 4'b0000;
    a   = 32'h11111111;
    b   = 32'h22222222;
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("midstream reset result=%h zero=%b", result, zero);
    check("mid_rst_res", result, 32'h0);
    check("mid_rst_zero", {31'h0, zero}, 32'h1);
    rst = 1'b0;
    run_vec("resume", 4'b0000, 32'h11111111, 32'h22222222, 32'h33333333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
